// File: rtl/sdspi_slave.sv
// SPI mode-3 peripheral byte engine: oversamples SCLK/MOSI/CS in the clk domain,
// deserializes MOSI into bytes and serializes a buffered response onto MISO.
module sdspi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spiSCLK,
  input  logic       spiMOSI,
  input  logic       spiCS,
  output logic       spiMISO,
  output logic [7:0] rxDATA,
  output logic       rxSTB,
  input  logic [7:0] txDATA,
  input  logic       txWR,
  output logic       txFULL,
  output logic       txUNDER,
  output logic       csACTIVE,
  output logic       frameEND
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_hist;
  logic                   cs_hist;
  logic [2:0]             bitcnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic [7:0]             hold;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  // MOSI runs through the same depth as SCLK so the bit sampled on a detected
  // rising edge is the one the master presented around that edge.
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s &  sclk_hist;
  assign cs_rise   =  cs_s   & ~cs_hist;
  assign cs_fall   = ~cs_s   &  cs_hist;

  // NOTE: every register here is state, so all updates are non-blocking; a
  // blocking write would let later statements see the new value within the
  // same edge and break the shift/load ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizers preset to the idle-high line level so reset release
      // never looks like a CS or SCLK edge.
      sclk_sync <= '1;
      mosi_sync <= '1;
      cs_sync   <= '1;
      sclk_hist <= 1'b1;
      cs_hist   <= 1'b1;
      state     <= IDLE;
      bitcnt    <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'hFF;
      hold      <= 8'h00;
      spiMISO   <= 1'b1;
      rxDATA    <= 8'hFF;
      rxSTB     <= 1'b0;
      txFULL    <= 1'b0;
      txUNDER   <= 1'b0;
      csACTIVE  <= 1'b0;
      frameEND  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spiSCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spiMOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spiCS};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
      csACTIVE  <= ~cs_s;

      rxSTB    <= 1'b0;
      txUNDER  <= 1'b0;
      frameEND <= 1'b0;

      // A write colliding with a load still lands; the load below reads the
      // pre-write hold value and leaves txFULL set.
      if (txWR) begin
        hold   <= txDATA;
        txFULL <= 1'b1;
      end

      case (state)
        IDLE: begin
          spiMISO <= 1'b1;
          if (cs_fall) begin
            state    <= ACTIVE;
            bitcnt   <= 3'd0;
            rx_shift <= 8'h00;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            state    <= IDLE;
            bitcnt   <= 3'd0;
            spiMISO  <= 1'b1;
            frameEND <= 1'b1;
          end else if (sclk_fall) begin
            if (bitcnt == 3'd0) begin
              if (txFULL) begin
                tx_shift <= hold;
                spiMISO  <= hold[7];
                if (!txWR) txFULL <= 1'b0;
              end else begin
                tx_shift <= IDLE_BYTE;
                spiMISO  <= IDLE_BYTE[7];
                txUNDER  <= 1'b1;
              end
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b1};
              spiMISO  <= tx_shift[6];
            end
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              rxDATA <= {rx_shift[6:0], mosi_s};
              rxSTB  <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
